// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StExec,
        StUpdate,
        StHalt,
        StTrap
    } state_e;

    localparam logic [31:0] NopInst        = 32'h0000_0013;
    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_instret.sv
// Retired-instruction counter: 32-bit, wraps silently.
module instret_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC and walks each instruction through fetch, execute and PC update.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        ex_done,
    input  logic [31:0] npc_in,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic        halted,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic [31:0] instret
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] npc_q;
    logic [31:0] inst_q;
    logic        inst_valid_q;
    logic        imem_req_q;
    logic        halted_q;
    logic        trap_q;
    logic [31:0] trap_pc_q;
    logic        retire;

    // All outputs are registered; each is set on the edge entering the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            npc_q        <= '0;
            inst_q       <= NopInst;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            halted_q     <= 1'b0;
            trap_q       <= 1'b0;
            trap_pc_q    <= '0;
        end else begin
            inst_valid_q <= 1'b0;
            case (state_q)
                StBoot: begin
                    if (halt_req) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= StFetch;
                        imem_req_q <= 1'b1;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        inst_q       <= imem_rdata;
                        inst_valid_q <= 1'b1;
                        imem_req_q   <= 1'b0;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    if (ex_done) begin
                        npc_q   <= npc_in;
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    // Misalignment wins over a pending halt.
                    if (npc_q[1:0] != 2'b00) begin
                        trap_q    <= 1'b1;
                        trap_pc_q <= npc_q;
                        state_q   <= StTrap;
                    end else begin
                        pc_q <= npc_q;
                        if (halt_req) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end else begin
                            state_q    <= StFetch;
                            imem_req_q <= 1'b1;
                        end
                    end
                end
                StHalt: begin
                    if (!halt_req) begin
                        state_q    <= StFetch;
                        halted_q   <= 1'b0;
                        imem_req_q <= 1'b1;
                    end
                end
                StTrap: begin
                    state_q <= StTrap;
                end
                default: begin
                    state_q <= StTrap;
                end
            endcase
        end
    end

    assign retire = (state_q == StUpdate) && (npc_q[1:0] == 2'b00);

    instret_counter u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (instret)
    );

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign halted     = halted_q;
    assign trap       = trap_q;
    assign trap_pc    = trap_pc_q;

endmodule
